// File: rtl/cim_xbar_tile.sv
// Behavioural CIM crossbar tile: input buffer, non-volatile weight array, unsigned MVM with busy.
// Optional DRAIN latency stage enabled by defining CIM_TILE_EXTRA_LAT_EN.
module cim_xbar_tile #(
    parameter int unsigned xbar_size     = 256,
    parameter int unsigned datatype_size = 4,
    parameter int unsigned extra_latency = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_we,
    input  logic [$clog2(xbar_size)-1:0]                  i_wr_addr,
    input  logic [datatype_size-1:0]                      i_wr_data,
    input  logic                                          i_wgt_we,
    input  logic [$clog2(xbar_size)-1:0]                  i_wgt_row,
    input  logic [$clog2(xbar_size/datatype_size)-1:0]    i_wgt_col,
    input  logic [datatype_size-1:0]                      i_wgt_data,
    input  logic                                          i_start,
    output logic                                          o_busy,
    input  logic [$clog2(xbar_size)-1:0]                  i_rd_addr,
    output logic [datatype_size-1:0]                      o_rd_data
);

    localparam int unsigned n_cols = xbar_size / datatype_size;
    localparam int unsigned acc_w  = 2 * datatype_size + $clog2(xbar_size);
    localparam int unsigned row_w  = $clog2(xbar_size);
    localparam int unsigned col_w  = $clog2(n_cols);

    localparam logic [row_w-1:0] row_last = row_w'(xbar_size - 1);
    localparam logic [acc_w-1:0] sat_max  =
        {{(acc_w - datatype_size){1'b0}}, {datatype_size{1'b1}}};

`ifdef CIM_TILE_EXTRA_LAT_EN
    typedef enum logic [1:0] {StIdle, StCompute, StDrain, StDone} state_e;
    // A zero-length drain skips straight to DONE.
    localparam state_e after_compute = (extra_latency == 0) ? StDone : StDrain;
    localparam int unsigned drain_w = (extra_latency > 1) ? $clog2(extra_latency) : 1;
    localparam logic [drain_w-1:0] drain_last = drain_w'(extra_latency - 1);
    logic [drain_w-1:0] drain_q;
`else
    typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;
    localparam state_e after_compute = StDone;
`endif

    state_e                   state_q, state_d;
    logic [row_w-1:0]         row_q;
    logic [datatype_size-1:0] ibuf_q [xbar_size];
    logic [datatype_size-1:0] w_q    [xbar_size][n_cols];
    logic [acc_w-1:0]         acc_q  [n_cols];
    logic [datatype_size-1:0] res_q  [n_cols];
    logic [datatype_size-1:0] rd_data_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (i_start) state_d = StCompute;
            StCompute: if (row_q == row_last) state_d = after_compute;
`ifdef CIM_TILE_EXTRA_LAT_EN
            StDrain:   if (drain_q == drain_last) state_d = StDone;
`endif
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

`ifdef CIM_TILE_EXTRA_LAT_EN
    always_ff @(posedge clk) begin
        if (rst || state_q != StDrain) drain_q <= '0;
        else                           drain_q <= drain_q + drain_w'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= '0;
            rd_data_q <= '0;
            for (int r = 0; r < xbar_size; r++) ibuf_q[r] <= '0;
            for (int c = 0; c < n_cols; c++) begin
                acc_q[c] <= '0;
                res_q[c] <= '0;
            end
        end else begin
            if (state_q == StIdle) begin
                if (i_we) ibuf_q[i_wr_addr] <= i_wr_data;
                if (i_start) begin
                    row_q <= '0;
                    for (int c = 0; c < n_cols; c++) acc_q[c] <= '0;
                end
            end
            if (state_q == StCompute) begin
                row_q <= row_q + row_w'(1);
                for (int c = 0; c < n_cols; c++) begin
                    acc_q[c] <= acc_q[c] + acc_w'(ibuf_q[row_q]) * acc_w'(w_q[row_q][c]);
                end
            end
            if (state_q == StDone) begin
                for (int c = 0; c < n_cols; c++) begin
                    res_q[c] <= (acc_q[c] > sat_max) ? '1 : acc_q[c][datatype_size-1:0];
                end
            end
            rd_data_q <= (32'(i_rd_addr) < n_cols) ? res_q[i_rd_addr[col_w-1:0]] : '0;
        end
    end

    // Weight cells are non-volatile: never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StIdle && i_wgt_we) w_q[i_wgt_row][i_wgt_col] <= i_wgt_data;
    end

    assign o_busy    = (state_q != StIdle);
    assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_cim_xbar_tile.sv
// Scoreboard bench for cim_xbar_tile: reference MVM model, queued expectations, decoupled monitors.
module tb_cim_xbar_tile;

    localparam int XS = 256;
    localparam int DS = 4;
    localparam int NC = XS / DS;
`ifdef CIM_TILE_EXTRA_LAT_EN
    localparam int EXTRA = 8;
`else
    localparam int EXTRA = 0;
`endif
    localparam int BUSY = XS + 1 + EXTRA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_we = 1'b0, i_wgt_we = 1'b0, i_start = 1'b0;
    logic [7:0] i_wr_addr = '0, i_wgt_row = '0, i_rd_addr = '0;
    logic [5:0] i_wgt_col = '0;
    logic [3:0] i_wr_data = '0, i_wgt_data = '0;
    logic       o_busy;
    logic [3:0] o_rd_data;

    cim_xbar_tile dut (
        .clk        (clk),
        .rst        (rst),
        .i_we       (i_we),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_wgt_we   (i_wgt_we),
        .i_wgt_row  (i_wgt_row),
        .i_wgt_col  (i_wgt_col),
        .i_wgt_data (i_wgt_data),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int ibuf_m [XS];
    int w_m    [XS][NC];
    int res_m  [NC];
    int pend_m [NC];
    int exp_q[$], addr_q[$], busy_q[$];
    bit rd_req = 0, busy_s = 0, mon_on = 0;
    int busy_run = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read monitor: o_rd_data is valid one cycle after the address is presented.
    always @(posedge clk) begin
        if (rd_req) begin
            #1;
            if (exp_q.size() > 0) begin
                chk($sformatf("rd_data[%0d]", addr_q.pop_front()), int'(o_rd_data),
                    exp_q.pop_front());
            end
        end
    end

    // Busy monitor: measures each busy window and compares against the expected length.
    always @(posedge clk) begin
        #1;
        busy_s = o_busy;
        if (mon_on) begin
            if (o_busy) busy_run++;
            else if (busy_run > 0) begin
                if (busy_q.size() > 0) chk("busy_len", busy_run, busy_q.pop_front());
                else chk("busy_unexpected", busy_run, 0);
                busy_run = 0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_rd(input int a);
        return (a < NC) ? res_m[a] : 0;
    endfunction

    function automatic void compute();
        for (int c = 0; c < NC; c++) begin
            int s = 0;
            for (int r = 0; r < XS; r++) s += ibuf_m[r] * w_m[r][c];
            pend_m[c] = (s > 15) ? 15 : s;
        end
    endfunction

    task automatic step();
        @(negedge clk);
        i_we = 0; i_wgt_we = 0; i_start = 0; rd_req = 0;
    endtask

    task automatic rd(input int a, input bit hard, input int hv);
        step();
        i_rd_addr = 8'(a);
        rd_req = 1;
        addr_q.push_back(a);
        exp_q.push_back(hard ? hv : model_rd(a));
    endtask

    task automatic wr_i(input int r, input int v);
        step();
        i_we = 1; i_wr_addr = 8'(r); i_wr_data = 4'(v);
        ibuf_m[r] = v;
    endtask

    task automatic wr_w(input int r, input int c, input int v);
        step();
        i_wgt_we = 1; i_wgt_row = 8'(r); i_wgt_col = 6'(c); i_wgt_data = 4'(v);
        w_m[r][c] = v;
    endtask

    // now=1 issues start in the current cycle (back-to-back); abort_at>0 resets mid-run.
    task automatic do_run(input bit now, input bit junk, input int abort_at,
                          input bit sw, input int sw_addr, input int sw_val);
        int k = 0;
        bit done = 0;
        if (sw) ibuf_m[sw_addr] = sw_val;
        compute();
        if (!now) step();
        i_start = 1;
        if (sw) begin
            i_we = 1; i_wr_addr = 8'(sw_addr); i_wr_data = 4'(sw_val);
        end
        busy_q.push_back(abort_at > 0 ? abort_at : BUSY);
        for (int i = 0; i < BUSY + 20 && !done; i++) begin
            step();
            if (i == 0) chk("busy_rise", int'(busy_s), 1);
            if (!busy_s) done = 1;
            else begin
                k++;
                if (abort_at > 0 && k == abort_at) begin
                    rst = 1;
                    step();
                    rst = 0;
                    for (int r = 0; r < XS; r++) ibuf_m[r] = 0;
                    for (int c = 0; c < NC; c++) res_m[c] = 0;
                    return;
                end
                if (junk && (k == 50 || $urandom_range(0, 15) == 0)) begin
                    i_start = 1;
                    i_we = 1;
                    i_wr_addr = (k == 50) ? 8'd0 : 8'($urandom_range(0, XS - 1));
                    i_wr_data = (k == 50) ? 4'd0 : 4'($urandom_range(0, 15));
                    i_wgt_we = 1;
                    i_wgt_row = 8'($urandom_range(0, XS - 1));
                    i_wgt_col = 6'($urandom_range(0, NC - 1));
                    i_wgt_data = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 3) == 0) begin
                    int a = $urandom_range(0, XS - 1);
                    i_rd_addr = 8'(a);
                    rd_req = 1;
                    addr_q.push_back(a);
                    exp_q.push_back(model_rd(a));
                end
            end
        end
        if (!done) chk("run_timeout", 0, 1);
        for (int c = 0; c < NC; c++) res_m[c] = pend_m[c];
    endtask

    initial begin
        for (int r = 0; r < XS; r++) ibuf_m[r] = 0;
        for (int c = 0; c < NC; c++) res_m[c] = 0;
        repeat (2) @(posedge clk);
        step();
        rst = 0;
        mon_on = 1;
        chk("busy_after_reset", int'(o_busy), 0);
        for (int a = 0; a < NC; a++) rd(a, 1, 0);
        rd(200, 1, 0);

        // Every weight cell gets a known random value.
        for (int r = 0; r < XS; r++)
            for (int c = 0; c < NC; c++) wr_w(r, c, $urandom_range(0, 15));

        // Basic MVM
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < NC; c++) wr_w(r, c, (c == 0) ? 1 : (c == 5) ? 2 : 0);
        for (int r = 0; r < 4; r++) wr_i(r, r + 1);
        do_run(0, 0, 0, 0, 0, 0);
        rd(0, 1, 10); rd(5, 1, 15); rd(1, 1, 0); rd(100, 1, 0);
        for (int i = 0; i < 16; i++) rd($urandom_range(0, XS - 1), 0, 0);

        // Saturation, with ignored start/write mid-run, then rerun
        for (int r = 0; r < XS; r++) wr_i(r, 15);
        for (int r = 0; r < XS; r++) wr_w(r, 2, 15);
        do_run(0, 1, 0, 0, 0, 0);
        rd(2, 1, 15);
        for (int a = 0; a < NC; a++) rd(a, 0, 0);
        do_run(0, 0, 0, 0, 0, 0);
        rd(2, 1, 15);
        for (int a = 0; a < NC; a++) rd(a, 0, 0);

        // Reset mid-COMPUTE, then rerun with retained weights
        do_run(0, 0, 100, 0, 0, 0);
        rd(0, 1, 0); rd(2, 1, 0);
        for (int r = 0; r < 4; r++) wr_i(r, r + 1);
        do_run(0, 0, 0, 0, 0, 0);
        rd(0, 1, 10); rd(5, 1, 15); rd(1, 1, 0);

        // Back-to-back: second start in the first idle cycle, with ibuf[0]=0 written alongside
        do_run(0, 0, 0, 0, 0, 0);
        do_run(1, 0, 0, 1, 0, 0);
        rd(0, 1, 9); rd(5, 1, 15);

        // Randomized runs
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 64; i++)
                wr_w($urandom_range(0, XS - 1), $urandom_range(0, NC - 1), $urandom_range(0, 3));
            for (int r = 0; r < XS; r++) wr_i(r, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : 0);
            do_run(0, 1, 0, 0, 0, 0);
            if (it % 2 == 1) do_run(1, 1, 0, 1, $urandom_range(0, XS - 1), $urandom_range(0, 15));
            for (int i = 0; i < 16; i++) rd($urandom_range(0, XS - 1), 0, 0);
        end

        repeat (4) step();
        chk("rd_queue_drained", exp_q.size(), 0);
        chk("busy_queue_drained", busy_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
